// File: rtl/fsm_branch_jump_ctrl_if.sv
// Bundle between the control-transfer FSM slice and the rest of the Control Unit / DataFlow.
// The master drives instruction fields and comparator flags; the slave (the FSM) drives loads and selects.
interface fsm_branch_jump_ctrl_if;
    logic       start;
    logic       is_branch;
    logic       is_jalr;
    logic [2:0] funct3;
    logic       eq;
    logic       ls;
    logic       lu;
    logic [1:0] alu_tgt_lo;

    logic [2:0] func3;
    logic [1:0] sel_rd;
    logic       load_data_memory;
    logic       write_mem;
    logic       load_ins;
    logic       load_rs1;
    logic       load_rs2;
    logic       load_imm;
    logic       load_alu;
    logic       load_pc_alu;
    logic       load_flags;
    logic       load_regfile;
    logic       load_pc;
    logic       sub_sra;
    logic       sel_alu_a;
    logic       sel_alu_b;
    logic       sel_pc_next;
    logic       sel_pc_alu;
    logic       clr_lsb;
    logic       busy;
    logic       done;
    logic       misalign_exc;
    logic       illegal_insn;

    modport master (
        output start, is_branch, is_jalr, funct3, eq, ls, lu, alu_tgt_lo,
        input  func3, sel_rd, load_data_memory, write_mem,
        input  load_ins, load_rs1, load_rs2, load_imm, load_alu, load_pc_alu,
        input  load_flags, load_regfile, load_pc,
        input  sub_sra, sel_alu_a, sel_alu_b, sel_pc_next, sel_pc_alu, clr_lsb,
        input  busy, done, misalign_exc, illegal_insn
    );

    modport slave (
        input  start, is_branch, is_jalr, funct3, eq, ls, lu, alu_tgt_lo,
        output func3, sel_rd, load_data_memory, write_mem,
        output load_ins, load_rs1, load_rs2, load_imm, load_alu, load_pc_alu,
        output load_flags, load_regfile, load_pc,
        output sub_sra, sel_alu_a, sel_alu_b, sel_pc_next, sel_pc_alu, clr_lsb,
        output busy, done, misalign_exc, illegal_insn
    );
endinterface

// File: rtl/fsm_branch_jump_ctrl.sv
// Multi-cycle control FSM for JAL, JALR and B-type branches with start/done/busy handshake
// and instruction-address-misaligned trapping. Outputs are registered, decoded from the next state.
module fsm_branch_jump_ctrl #(
    parameter int unsigned IALIGN      = 32,
    parameter bit          FAST_BRANCH = 1'b0,
    parameter logic [1:0]  SEL_RD_LINK = 2'b11,
    parameter logic [2:0]  FUNC_ADD    = 3'b000
) (
    input logic                   clk,
    input logic                   rst_n,
    fsm_branch_jump_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        DECODE = 4'd1,
        J_EXEC = 4'd2,
        J_CHK  = 4'd3,
        J_WB   = 4'd4,
        B_CMP  = 4'd5,
        FLAGS  = 4'd6,
        B_TGT  = 4'd7,
        B_CHK  = 4'd8,
        B_WB   = 4'd9,
        TRAP   = 4'd10,
        ILL    = 4'd11
    } state_t;

    typedef struct packed {
        logic load_ins;
        logic load_rs1;
        logic load_rs2;
        logic load_imm;
        logic load_alu;
        logic load_pc_alu;
        logic load_flags;
        logic load_regfile;
        logic load_pc;
        logic sub_sra;
        logic sel_alu_a;
        logic sel_alu_b;
        logic sel_pc_next;
        logic sel_pc_alu;
        logic clr_lsb;
        logic busy;
        logic done;
        logic misalign_exc;
        logic illegal_insn;
    } outs_t;

    // Only bit 1 can misalign a 32-bit target; bit 0 is always even by construction.
    localparam logic [1:0] ALIGN_MASK = (IALIGN == 32) ? 2'b10 : 2'b00;

    state_t state_q, state_d;
    outs_t  outs_q, outs_d;
    logic   taken_q, taken_d;
    logic   illegal_q, illegal_d;
    logic   bad_state;
    logic   misaligned;

    always_comb begin
        state_d    = state_q;
        taken_d    = taken_q;
        illegal_d  = illegal_q;
        bad_state  = 1'b0;
        misaligned = (bus.alu_tgt_lo & ALIGN_MASK) != 2'b00;

        case (state_q)
            IDLE:    if (bus.start) state_d = DECODE;
            DECODE:  state_d = bus.is_branch ? B_CMP : J_EXEC;
            J_EXEC:  state_d = J_CHK;
            J_CHK:   state_d = misaligned ? TRAP : J_WB;
            J_WB:    state_d = IDLE;
            B_CMP:   state_d = FAST_BRANCH ? B_TGT : FLAGS;
            FLAGS:   state_d = B_TGT;
            B_TGT: begin
                state_d   = B_CHK;
                illegal_d = (bus.funct3[2:1] == 2'b01);
                case (bus.funct3[2:1])
                    2'b00:   taken_d = bus.eq ^ bus.funct3[0];
                    2'b10:   taken_d = bus.ls ^ bus.funct3[0];
                    2'b11:   taken_d = bus.lu ^ bus.funct3[0];
                    default: taken_d = 1'b0;
                endcase
            end
            // alu_tgt_lo is only valid here, one cycle after the ALU register loaded in B_TGT.
            B_CHK: begin
                if (illegal_q)                    state_d = ILL;
                else if (taken_q && misaligned)   state_d = TRAP;
                else                              state_d = B_WB;
            end
            B_WB:    state_d = IDLE;
            TRAP:    state_d = IDLE;
            ILL:     state_d = IDLE;
            default: begin
                state_d   = IDLE;
                bad_state = 1'b1;
            end
        endcase

        outs_d      = '0;
        outs_d.busy = (state_d != IDLE) && !bad_state;
        if (!bad_state) begin
            case (state_d)
                IDLE:   outs_d.load_ins = 1'b1;
                DECODE: begin
                    outs_d.load_rs1 = 1'b1;
                    outs_d.load_rs2 = 1'b1;
                    outs_d.load_imm = 1'b1;
                end
                J_EXEC: begin
                    outs_d.sel_alu_a   = ~bus.is_jalr;
                    outs_d.sel_alu_b   = 1'b1;
                    outs_d.load_alu    = 1'b1;
                    outs_d.load_pc_alu = 1'b1;
                    outs_d.clr_lsb     = bus.is_jalr;
                end
                J_WB: begin
                    outs_d.load_regfile = 1'b1;
                    outs_d.sel_pc_next  = 1'b1;
                    outs_d.load_pc      = 1'b1;
                    outs_d.done         = 1'b1;
                end
                B_CMP: begin
                    outs_d.sub_sra    = 1'b1;
                    outs_d.load_flags = 1'b1;
                end
                B_TGT: begin
                    outs_d.sel_alu_a = 1'b1;
                    outs_d.sel_alu_b = 1'b1;
                    outs_d.load_alu  = 1'b1;
                end
                B_WB: begin
                    outs_d.load_pc    = 1'b1;
                    outs_d.sel_pc_alu = taken_q;
                    outs_d.done       = 1'b1;
                end
                TRAP: begin
                    outs_d.misalign_exc = 1'b1;
                    outs_d.done         = 1'b1;
                end
                ILL: begin
                    outs_d.illegal_insn = 1'b1;
                    outs_d.done         = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            outs_q    <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            outs_q    <= outs_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.func3            = FUNC_ADD;
    assign bus.sel_rd           = SEL_RD_LINK;
    assign bus.load_data_memory = 1'b0;
    assign bus.write_mem        = 1'b0;
    assign bus.load_ins         = outs_q.load_ins;
    assign bus.load_rs1         = outs_q.load_rs1;
    assign bus.load_rs2         = outs_q.load_rs2;
    assign bus.load_imm         = outs_q.load_imm;
    assign bus.load_alu         = outs_q.load_alu;
    assign bus.load_pc_alu      = outs_q.load_pc_alu;
    assign bus.load_flags       = outs_q.load_flags;
    assign bus.load_regfile     = outs_q.load_regfile;
    assign bus.load_pc          = outs_q.load_pc;
    assign bus.sub_sra          = outs_q.sub_sra;
    assign bus.sel_alu_a        = outs_q.sel_alu_a;
    assign bus.sel_alu_b        = outs_q.sel_alu_b;
    assign bus.sel_pc_next      = outs_q.sel_pc_next;
    assign bus.sel_pc_alu       = outs_q.sel_pc_alu;
    assign bus.clr_lsb          = outs_q.clr_lsb;
    assign bus.busy             = outs_q.busy;
    assign bus.done             = outs_q.done;
    assign bus.misalign_exc     = outs_q.misalign_exc;
    assign bus.illegal_insn     = outs_q.illegal_insn;

endmodule

// File: tb/tb_fsm_branch_jump_ctrl.sv
// Bench for fsm_branch_jump_ctrl: two instances (IALIGN=32/slow flags, IALIGN=16/fast branch)
// driven with the same directed and random instructions, checked against an outcome-level model.
module tb_fsm_branch_jump_ctrl;

    localparam int B_LOAD_INS  = 0;
    localparam int B_LOAD_RS1  = 1;
    localparam int B_LOAD_ALU  = 4;
    localparam int B_LOAD_FLAG = 6;
    localparam int B_LOAD_RF   = 7;
    localparam int B_LOAD_PC   = 8;
    localparam int B_SUB_SRA   = 9;
    localparam int B_SEL_A     = 10;
    localparam int B_SEL_NEXT  = 12;
    localparam int B_SEL_PCALU = 13;
    localparam int B_CLR_LSB   = 14;
    localparam int B_BUSY      = 15;
    localparam int B_DONE      = 16;
    localparam int B_MIS       = 17;
    localparam int B_ILL       = 18;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       is_branch = 1'b0;
    logic       is_jalr = 1'b0;
    logic [2:0] funct3 = 3'b000;
    logic       eq = 1'b0;
    logic       ls = 1'b0;
    logic       lu = 1'b0;
    logic [1:0] tgt = 2'b00;

    int errors = 0;
    int checks = 0;

    logic [18:0] o0, o1;
    logic [6:0]  k0, k1;

    always #5 clk = ~clk;

    fsm_branch_jump_ctrl_if bus0 ();
    fsm_branch_jump_ctrl_if bus1 ();

    assign bus0.start = start;      assign bus1.start = start;
    assign bus0.is_branch = is_branch; assign bus1.is_branch = is_branch;
    assign bus0.is_jalr = is_jalr;  assign bus1.is_jalr = is_jalr;
    assign bus0.funct3 = funct3;    assign bus1.funct3 = funct3;
    assign bus0.eq = eq;            assign bus1.eq = eq;
    assign bus0.ls = ls;            assign bus1.ls = ls;
    assign bus0.lu = lu;            assign bus1.lu = lu;
    assign bus0.alu_tgt_lo = tgt;   assign bus1.alu_tgt_lo = tgt;

    fsm_branch_jump_ctrl #(.IALIGN(32), .FAST_BRANCH(1'b0), .SEL_RD_LINK(2'b11), .FUNC_ADD(3'b000))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    fsm_branch_jump_ctrl #(.IALIGN(16), .FAST_BRANCH(1'b1), .SEL_RD_LINK(2'b11), .FUNC_ADD(3'b000))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign o0 = {bus0.illegal_insn, bus0.misalign_exc, bus0.done, bus0.busy, bus0.clr_lsb,
                 bus0.sel_pc_alu, bus0.sel_pc_next, bus0.sel_alu_b, bus0.sel_alu_a, bus0.sub_sra,
                 bus0.load_pc, bus0.load_regfile, bus0.load_flags, bus0.load_pc_alu, bus0.load_alu,
                 bus0.load_imm, bus0.load_rs2, bus0.load_rs1, bus0.load_ins};
    assign o1 = {bus1.illegal_insn, bus1.misalign_exc, bus1.done, bus1.busy, bus1.clr_lsb,
                 bus1.sel_pc_alu, bus1.sel_pc_next, bus1.sel_alu_b, bus1.sel_alu_a, bus1.sub_sra,
                 bus1.load_pc, bus1.load_regfile, bus1.load_flags, bus1.load_pc_alu, bus1.load_alu,
                 bus1.load_imm, bus1.load_rs2, bus1.load_rs1, bus1.load_ins};
    assign k0 = {bus0.func3, bus0.sel_rd, bus0.load_data_memory, bus0.write_mem};
    assign k1 = {bus1.func3, bus1.sel_rd, bus1.load_data_memory, bus1.write_mem};

    task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic [18:0] exp);
        check(tag, 0, 32'(o0), 32'(exp));
        check(tag, 1, 32'(o1), 32'(exp));
    endtask

    // Reference: taken decision straight from the branch condition table.
    function automatic bit branch_taken(input logic [2:0] f3, input logic e, input logic l, input logic u);
        case (f3)
            3'b000:  return e;
            3'b001:  return !e;
            3'b100:  return l;
            3'b101:  return !l;
            3'b110:  return u;
            3'b111:  return !u;
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_insn(input logic br, input logic jr, input logic [2:0] f3,
                            input logic e, input logic l, input logic u,
                            input logic [1:0] t, input bit poke);
        logic [18:0] obs [2][8];
        is_branch = br; is_jalr = jr; funct3 = f3; eq = e; ls = l; lu = u; tgt = t;
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 8; c++) begin
            obs[0][c] = o0;
            obs[1][c] = o1;
            start = poke && (c < 2);
            if (c < 7) begin
                @(posedge clk); #1;
            end
        end
        for (int d = 0; d < 2; d++) begin
            bit fast, ia32, mis, ill, taken, trap, jwb, bwb;
            int dc, first_done, n_done, n_pc, n_rf, n_mis, n_ill, tgt_cyc;
            fast  = (d == 1);
            ia32  = (d == 0);
            dc    = br ? (fast ? 4 : 5) : 3;
            mis   = ia32 && t[1];
            ill   = br && (f3 == 3'b010 || f3 == 3'b011);
            taken = br && branch_taken(f3, e, l, u);
            trap  = !ill && (br ? (taken && mis) : mis);
            jwb   = !br && !mis;
            bwb   = br && !ill && !trap;
            first_done = 99;
            n_done = 0; n_pc = 0; n_rf = 0; n_mis = 0; n_ill = 0;
            for (int c = 0; c < 8; c++) begin
                if (obs[d][c][B_DONE] && first_done == 99) first_done = c;
                n_done += int'(obs[d][c][B_DONE]);
                n_pc   += int'(obs[d][c][B_LOAD_PC]);
                n_rf   += int'(obs[d][c][B_LOAD_RF]);
                n_mis  += int'(obs[d][c][B_MIS]);
                n_ill  += int'(obs[d][c][B_ILL]);
            end
            check("done_cycle", d, 32'(first_done), 32'(dc));
            check("done_count", d, 32'(n_done), 32'd1);
            check("load_pc_count", d, 32'(n_pc), 32'(jwb || bwb));
            check("load_regfile_count", d, 32'(n_rf), 32'(jwb));
            check("misalign_count", d, 32'(n_mis), 32'(trap));
            check("illegal_count", d, 32'(n_ill), 32'(ill));
            check("decode_loads", d, 32'({obs[d][0][B_BUSY], obs[d][0][B_LOAD_RS1]}), 32'b11);
            check("sel_pc_alu_at_done", d, 32'(obs[d][dc][B_SEL_PCALU]), 32'(bwb && taken));
            check("sel_pc_next_at_done", d, 32'(obs[d][dc][B_SEL_NEXT]), 32'(jwb));
            check("busy_at_done", d, 32'(obs[d][dc][B_BUSY]), 32'd1);
            check("busy_after_done", d, 32'({obs[d][dc+1][B_BUSY], obs[d][dc+2][B_BUSY]}), 32'b00);
            check("load_ins_after_done", d, 32'(obs[d][dc+1][B_LOAD_INS]), 32'd1);
            if (!br) begin
                check("j_exec_sel_a", d, 32'(obs[d][1][B_SEL_A]), 32'(!jr));
                check("j_exec_clr_lsb", d, 32'(obs[d][1][B_CLR_LSB]), 32'(jr));
                check("j_exec_load_alu", d, 32'(obs[d][1][B_LOAD_ALU]), 32'd1);
            end else begin
                tgt_cyc = fast ? 2 : 3;
                check("b_cmp_flags", d, 32'({obs[d][1][B_SUB_SRA], obs[d][1][B_LOAD_FLAG]}), 32'b11);
                check("b_tgt_alu", d, 32'({obs[d][tgt_cyc][B_SEL_A], obs[d][tgt_cyc][B_LOAD_ALU]}), 32'b11);
            end
        end
    endtask

    task automatic reset_mid_branch();
        int pc_seen;
        is_branch = 1'b1; is_jalr = 1'b0; funct3 = 3'b000; eq = 1'b1; ls = 1'b0; lu = 1'b0; tgt = 2'b00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_both("reset_async_outputs", 19'd0);
        pc_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            pc_seen += int'(o0[B_LOAD_PC]) + int'(o1[B_LOAD_PC]) + int'(o0[B_LOAD_RF]) + int'(o1[B_LOAD_RF]);
            check_both("reset_held_outputs", 19'd0);
        end
        check("reset_no_writes", 0, 32'(pc_seen), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_both("idle_after_reset", 19'd1 << B_LOAD_INS);
        end
    endtask

    initial begin
        #2;
        check_both("reset_initial", 19'd0);
        check("constants", 0, 32'(k0), 32'(7'b000_11_00));
        check("constants", 1, 32'(k1), 32'(7'b000_11_00));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_both("first_idle_load_ins", 19'd1 << B_LOAD_INS);

        // Jumps: JAL aligned, JALR misaligned, JALR aligned, JAL misaligned
        run_insn(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        run_insn(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        run_insn(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        run_insn(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);

        reset_mid_branch();

        // Branch sweep: six legal codes against one-hot flag patterns
        for (int i = 0; i < 6; i++) begin
            logic [2:0] codes [6];
            codes = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
            run_insn(1'b1, 1'b0, codes[i], 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
            run_insn(1'b1, 1'b0, codes[i], 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
            run_insn(1'b1, 1'b0, codes[i], 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        end

        // Taken BEQ to misaligned target, not-taken BNE to the same target
        run_insn(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        run_insn(1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);

        // Illegal branch codes, with start poked while busy
        run_insn(1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1);
        run_insn(1'b1, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] r;
            r = $urandom;
            run_insn(r[0], r[1], r[4:2], r[5], r[6], r[7], r[9:8], r[10]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
